// File: rtl/gpu_pkg.sv
// Shared GPU definitions: default field widths, opcodes and the instruction record.
package gpu_pkg;

  localparam int DEF_WIDTH_BITS   = 10;
  localparam int DEF_HEIGHT_BITS  = 9;
  localparam int DEF_CHANNEL_BITS = 8;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_CLEAR  = 4'h1;
  localparam logic [3:0] OP_PIXEL  = 4'h2;
  localparam logic [3:0] OP_LINE   = 4'h3;
  localparam logic [3:0] OP_CIRCLE = 4'h4;
  localparam logic [3:0] OP_RECT   = 4'h5;

  typedef struct packed {
    logic [3:0]                  opcode;
    logic [DEF_WIDTH_BITS-1:0]   x1;
    logic [DEF_HEIGHT_BITS-1:0]  y1;
    logic [DEF_WIDTH_BITS-1:0]   x2;
    logic [DEF_HEIGHT_BITS-1:0]  y2;
    logic [DEF_WIDTH_BITS-1:0]   rad;
    logic [DEF_CHANNEL_BITS-1:0] r;
    logic [DEF_CHANNEL_BITS-1:0] g;
    logic [DEF_CHANNEL_BITS-1:0] b;
    logic [2:0]                  quad;
  } gpu_instr_t;

endpackage

// File: rtl/gpu_instr_fifo_if.sv
// Host/draw-engine side bundle of the instruction queue.
interface gpu_instr_fifo_if
  import gpu_pkg::*;
#(
  parameter int WIDTH_BITS   = DEF_WIDTH_BITS,
  parameter int HEIGHT_BITS  = DEF_HEIGHT_BITS,
  parameter int CHANNEL_BITS = DEF_CHANNEL_BITS
) ();

  logic [3:0]              opcode_i;
  logic [WIDTH_BITS-1:0]   x1_i, x2_i, rad_i;
  logic [HEIGHT_BITS-1:0]  y1_i, y2_i;
  logic [CHANNEL_BITS-1:0] r_i, g_i, b_i;
  logic [2:0]              quad_i;
  logic                    write_enable_i;
  logic                    push_instruction_i;
  logic                    pop_instruction_i;

  logic                    fifo_empty_o;
  logic                    fifo_full_o;
  logic [3:0]              opcode_o;
  logic [WIDTH_BITS-1:0]   x1_o, x2_o, rad_o;
  logic [HEIGHT_BITS-1:0]  y1_o, y2_o;
  logic [CHANNEL_BITS-1:0] r_o, g_o, b_o;
  logic [2:0]              quad_o;

  modport master (
    output opcode_i, x1_i, y1_i, x2_i, y2_i, rad_i, r_i, g_i, b_i, quad_i,
           write_enable_i, push_instruction_i, pop_instruction_i,
    input  fifo_empty_o, fifo_full_o,
           opcode_o, x1_o, y1_o, x2_o, y2_o, rad_o, r_o, g_o, b_o, quad_o
  );

  modport slave (
    input  opcode_i, x1_i, y1_i, x2_i, y2_i, rad_i, r_i, g_i, b_i, quad_i,
           write_enable_i, push_instruction_i, pop_instruction_i,
    output fifo_empty_o, fifo_full_o,
           opcode_o, x1_o, y1_o, x2_o, y2_o, rad_o, r_o, g_o, b_o, quad_o
  );

endinterface

// File: rtl/gpu_sync_fifo.sv
// Generic first-word-fall-through synchronous FIFO; head reads as zero when empty.
module gpu_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [AW-1:0]                wr_ptr_q, rd_ptr_q;
  logic [AW:0]                  count_q;
  logic                         do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign do_pop  = rd_en && !empty;
  // A full queue still accepts a push when the head leaves on the same edge.
  assign do_push = wr_en && (!full || do_pop);
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/gpu_instr_fifo.sv
// Instruction queue: host stages one instruction, commits it into the FIFO, engine pops the head.
module gpu_instr_fifo
  import gpu_pkg::*;
#(
  parameter int WIDTH_BITS   = DEF_WIDTH_BITS,
  parameter int HEIGHT_BITS  = DEF_HEIGHT_BITS,
  parameter int CHANNEL_BITS = DEF_CHANNEL_BITS,
  parameter int DEPTH        = 8
) (
  input logic             clk,
  input logic             rst,
  gpu_instr_fifo_if.slave bus
);

  typedef struct packed {
    logic [3:0]              opcode;
    logic [WIDTH_BITS-1:0]   x1;
    logic [HEIGHT_BITS-1:0]  y1;
    logic [WIDTH_BITS-1:0]   x2;
    logic [HEIGHT_BITS-1:0]  y2;
    logic [WIDTH_BITS-1:0]   rad;
    logic [CHANNEL_BITS-1:0] r;
    logic [CHANNEL_BITS-1:0] g;
    logic [CHANNEL_BITS-1:0] b;
    logic [2:0]              quad;
  } instr_t;

  localparam int INSTR_W = $bits(instr_t);

  instr_t               stage_q, stage_d, head;
  logic [INSTR_W-1:0]   head_bits;

  always_comb begin
    stage_d        = '0;
    stage_d.opcode = bus.opcode_i;
    stage_d.x1     = bus.x1_i;
    stage_d.y1     = bus.y1_i;
    stage_d.x2     = bus.x2_i;
    stage_d.y2     = bus.y2_i;
    stage_d.rad    = bus.rad_i;
    stage_d.r      = bus.r_i;
    stage_d.g      = bus.g_i;
    stage_d.b      = bus.b_i;
    stage_d.quad   = bus.quad_i;
  end

  // The FIFO captures stage_q from before the edge, so staging and pushing
  // on the same edge commits the previously staged instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     stage_q <= '0;
    else if (bus.write_enable_i) stage_q <= stage_d;
  end

  gpu_sync_fifo #(
    .DATA_W (INSTR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.push_instruction_i),
    .wr_data (stage_q),
    .rd_en   (bus.pop_instruction_i),
    .rd_data (head_bits),
    .empty   (bus.fifo_empty_o),
    .full    (bus.fifo_full_o)
  );

  assign head = instr_t'(head_bits);

  always_comb begin
    bus.opcode_o = head.opcode;
    bus.x1_o     = head.x1;
    bus.y1_o     = head.y1;
    bus.x2_o     = head.x2;
    bus.y2_o     = head.y2;
    bus.rad_o    = head.rad;
    bus.r_o      = head.r;
    bus.g_o      = head.g;
    bus.b_o      = head.b;
    bus.quad_o   = head.quad;
  end

endmodule

// File: tb/tb_gpu_instr_fifo.sv
// Directed self-checking bench for gpu_instr_fifo.
module tb_gpu_instr_fifo;
  import gpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  gpu_instr_fifo_if bus ();

  gpu_instr_fifo u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [3:0] op, input logic [9:0] x1, input logic [2:0] q);
    bus.opcode_i = op;
    bus.x1_i     = x1;
    bus.y1_i     = 9'(x1 + 10'd1);
    bus.x2_i     = x1 + 10'd2;
    bus.y2_i     = 9'(x1 + 10'd3);
    bus.rad_i    = x1 + 10'd4;
    bus.r_i      = 8'(x1);
    bus.g_i      = 8'(x1 + 10'd5);
    bus.b_i      = 8'(x1 + 10'd6);
    bus.quad_i   = q;
  endtask

  task automatic stage(input logic [9:0] x1, input logic [2:0] q);
    set_fields(OP_CIRCLE, x1, q);
    bus.write_enable_i = 1'b1;
    step();
    bus.write_enable_i = 1'b0;
  endtask

  task automatic push();
    bus.push_instruction_i = 1'b1;
    step();
    bus.push_instruction_i = 1'b0;
  endtask

  task automatic pop();
    bus.pop_instruction_i = 1'b1;
    step();
    bus.pop_instruction_i = 1'b0;
  endtask

  task automatic stage_push(input logic [9:0] x1, input logic [2:0] q);
    stage(x1, q);
    push();
  endtask

  initial begin
    bus.write_enable_i = 1'b0;
    bus.push_instruction_i = 1'b0;
    bus.pop_instruction_i = 1'b0;
    set_fields(OP_NOP, 10'd0, 3'd0);
    rst = 1'b1;
    #1;
    chk("rst_empty", 32'(bus.fifo_empty_o), 32'd1);
    chk("rst_full",  32'(bus.fifo_full_o),  32'd0);
    chk("rst_opc",   32'(bus.opcode_o),     32'd0);
    chk("rst_x2",    32'(bus.x2_o),         32'd0);
    chk("rst_quad",  32'(bus.quad_o),       32'd0);
    step();
    step();
    rst = 1'b0;
    step();

    // Single instruction with the exact plan fields.
    bus.opcode_i = 4'b0100; bus.x1_i = 10'd0; bus.y1_i = 9'd0; bus.x2_i = 10'd10;
    bus.y2_i = 9'd10; bus.rad_i = 10'd5; bus.r_i = 8'd32; bus.g_i = 8'd32;
    bus.b_i = 8'd32; bus.quad_i = 3'd1;
    bus.write_enable_i = 1'b1;
    step();
    bus.write_enable_i = 1'b0;
    chk("stage_no_push_empty", 32'(bus.fifo_empty_o), 32'd1);
    push();
    chk("one_empty", 32'(bus.fifo_empty_o), 32'd0);
    chk("one_opc",   32'(bus.opcode_o), 32'h4);
    chk("one_x1",    32'(bus.x1_o),     32'd0);
    chk("one_y1",    32'(bus.y1_o),     32'd0);
    chk("one_x2",    32'(bus.x2_o),     32'd10);
    chk("one_y2",    32'(bus.y2_o),     32'd10);
    chk("one_rad",   32'(bus.rad_o),    32'd5);
    chk("one_r",     32'(bus.r_o),      32'd32);
    chk("one_g",     32'(bus.g_o),      32'd32);
    chk("one_b",     32'(bus.b_o),      32'd32);
    chk("one_quad",  32'(bus.quad_o),   32'd1);
    pop();
    chk("one_pop_empty", 32'(bus.fifo_empty_o), 32'd1);
    chk("one_pop_x2",    32'(bus.x2_o),         32'd0);

    // Ordering: quads 1,0,1,2,3 then one pop.
    stage_push(10'd50, 3'd1);
    stage_push(10'd51, 3'd0);
    stage_push(10'd52, 3'd1);
    stage_push(10'd53, 3'd2);
    stage_push(10'd54, 3'd3);
    chk("ord_head_q",  32'(bus.quad_o), 32'd1);
    chk("ord_head_x1", 32'(bus.x1_o),   32'd50);
    pop();
    chk("ord_pop_q",   32'(bus.quad_o), 32'd0);
    chk("ord_pop_rad", 32'(bus.rad_o),  32'd55);
    chk("ord_full",    32'(bus.fifo_full_o), 32'd0);

    // Fill to eight, then a push into a full queue is dropped.
    for (int i = 0; i < 4; i++) begin
      chk("fill_not_full", 32'(bus.fifo_full_o), 32'd0);
      stage_push(10'(60 + i), 3'(i));
    end
    chk("full_flag", 32'(bus.fifo_full_o), 32'd1);
    stage_push(10'd99, 3'd7);
    chk("full_drop_flag", 32'(bus.fifo_full_o), 32'd1);
    chk("full_drop_head", 32'(bus.x1_o),        32'd51);

    // Drain across the wrapped pointers.
    begin
      logic [2:0] exp_q [8]  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3};
      logic [9:0] exp_x [8]  = '{10'd51, 10'd52, 10'd53, 10'd54, 10'd60, 10'd61, 10'd62, 10'd63};
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("drain_q%0d", i), 32'(bus.quad_o), 32'(exp_q[i]));
        chk($sformatf("drain_x%0d", i), 32'(bus.x1_o),   32'(exp_x[i]));
        pop();
      end
    end
    chk("drain_empty", 32'(bus.fifo_empty_o), 32'd1);
    chk("drain_x1",    32'(bus.x1_o),   32'd0);
    chk("drain_opc",   32'(bus.opcode_o), 32'd0);
    chk("drain_b",     32'(bus.b_o),    32'd0);
    pop();
    chk("pop9_empty", 32'(bus.fifo_empty_o), 32'd1);
    chk("pop9_full",  32'(bus.fifo_full_o),  32'd0);
    stage_push(10'd70, 3'd5);
    chk("pop9_ptr_x1", 32'(bus.x1_o), 32'd70);
    pop();

    // Stage and push on the same edge: the old staged value is committed.
    stage(10'd80, 3'd2);
    set_fields(OP_LINE, 10'd81, 3'd3);
    bus.write_enable_i = 1'b1;
    bus.push_instruction_i = 1'b1;
    step();
    bus.write_enable_i = 1'b0;
    bus.push_instruction_i = 1'b0;
    chk("same_edge_old_x1", 32'(bus.x1_o),     32'd80);
    chk("same_edge_old_op", 32'(bus.opcode_o), 32'(OP_CIRCLE));
    push();
    pop();
    chk("same_edge_new_x1", 32'(bus.x1_o),     32'd81);
    chk("same_edge_new_op", 32'(bus.opcode_o), 32'(OP_LINE));
    pop();
    chk("same_edge_empty", 32'(bus.fifo_empty_o), 32'd1);

    // Push and pop together while full.
    for (int i = 0; i < 8; i++) stage_push(10'(200 + i), 3'(i));
    chk("pp_full_pre", 32'(bus.fifo_full_o), 32'd1);
    stage(10'd300, 3'd6);
    bus.push_instruction_i = 1'b1;
    bus.pop_instruction_i  = 1'b1;
    step();
    bus.push_instruction_i = 1'b0;
    bus.pop_instruction_i  = 1'b0;
    chk("pp_full_flag", 32'(bus.fifo_full_o), 32'd1);
    chk("pp_full_head", 32'(bus.x1_o),        32'd201);
    for (int i = 0; i < 7; i++) pop();
    chk("pp_full_tail", 32'(bus.x1_o),   32'd300);
    chk("pp_full_tq",   32'(bus.quad_o), 32'd6);
    pop();
    chk("pp_full_drained", 32'(bus.fifo_empty_o), 32'd1);

    // Push and pop together while empty: push accepted, pop ignored.
    stage(10'd400, 3'd4);
    bus.push_instruction_i = 1'b1;
    bus.pop_instruction_i  = 1'b1;
    step();
    bus.push_instruction_i = 1'b0;
    bus.pop_instruction_i  = 1'b0;
    chk("pp_empty_flag", 32'(bus.fifo_empty_o), 32'd0);
    chk("pp_empty_head", 32'(bus.x1_o),         32'd400);

    // Asynchronous reset mid-cycle.
    stage_push(10'd500, 3'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_empty", 32'(bus.fifo_empty_o), 32'd1);
    chk("arst_x1",    32'(bus.x1_o),         32'd0);
    step();
    rst = 1'b0;
    push();
    chk("arst_stage_cleared_empty", 32'(bus.fifo_empty_o), 32'd0);
    chk("arst_stage_cleared_x1",    32'(bus.x1_o),         32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
